// File: rtl/sprite_row_scanout.sv
// sprite_row_scanout: streams one sprite from the packed image bus, one shifted row per handshake
module sprite_row_scanout #(
  parameter int IMAGECOUNT = 5,
  parameter int IMAGEWIDTH = 8,
  parameter int IMAGEHEIGHT = 8,
  parameter int TYPEW = 4,
  parameter int SHW = 5,
  localparam int IW = IMAGEHEIGHT > 1 ? $clog2(IMAGEHEIGHT) : 1,
  localparam int BW = $clog2(IMAGECOUNT * IMAGEWIDTH * IMAGEHEIGHT)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [IMAGECOUNT*IMAGEWIDTH*IMAGEHEIGHT-1:0] image,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic [TYPEW-1:0]                           req_type,
  input  logic [SHW-1:0]                             req_shift,
  output logic                                       row_valid,
  input  logic                                       row_ready,
  output logic [IMAGEWIDTH-1:0]                      row_data,
  output logic [IW-1:0]                              row_index,
  output logic                                       row_last,
  output logic                                       req_err
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [TYPEW-1:0] cur_type, sel_type;
  logic [SHW-1:0] cur_shift, sel_shift, mag;
  logic [IW-1:0] nk;
  logic [BW-1:0] base;
  logic [IMAGEWIDTH-1:0] raw, shifted;
  logic type_ok;
  // In IDLE the incoming request drives the fetch of row 0; in SCAN the latched request drives row k+1.
  always_comb begin
    type_ok = req_type != '0 && 32'(req_type) <= IMAGECOUNT;
    sel_type = state == SCAN ? cur_type : type_ok ? req_type : TYPEW'(1);
    sel_shift = state == SCAN ? cur_shift : req_shift;
    nk = state == SCAN ? row_index + IW'(1) : '0;
    base = BW'((32'(sel_type) - 32'd1) * 32'(IMAGEWIDTH * IMAGEHEIGHT) + 32'(nk) * 32'(IMAGEWIDTH));
    raw = image[base +: IMAGEWIDTH];
    mag = sel_shift[SHW-1] ? -sel_shift : sel_shift;
    shifted = sel_shift[SHW-1] ? raw >> mag : raw << mag;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      row_valid <= 1'b0;
      row_data <= '0;
      row_index <= '0;
      row_last <= 1'b0;
      req_err <= 1'b0;
      cur_type <= '0;
      cur_shift <= '0;
    end else begin
      req_err <= 1'b0;
      if (state == IDLE) begin
        if (req_valid && type_ok) begin
          cur_type <= req_type;
          cur_shift <= req_shift;
          row_data <= shifted;
          row_index <= nk;
          row_last <= nk == IW'(IMAGEHEIGHT - 1);
          row_valid <= 1'b1;
          req_ready <= 1'b0;
          state <= SCAN;
        end else if (req_valid) begin
          req_err <= 1'b1;
        end
      end else if (row_ready) begin
        if (row_last) begin
          row_valid <= 1'b0;
          row_last <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end else begin
          row_data <= shifted;
          row_index <= nk;
          row_last <= nk == IW'(IMAGEHEIGHT - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_row_scanout.sv
// tb_sprite_row_scanout: directed checks of sprite_row_scanout with a {type,row} patterned image bus
module tb_sprite_row_scanout;
  logic clk = 0, rst_n = 0, req_valid = 0, row_ready = 0;
  logic [319:0] image;
  logic [3:0] req_type = 0;
  logic [4:0] req_shift = 0;
  logic req_ready, row_valid, row_last, req_err;
  logic [7:0] row_data;
  logic [2:0] row_index;
  int n_vec = 0, n_err = 0;
  int got [8];

  sprite_row_scanout dut (
    .clk(clk), .rst_n(rst_n), .image(image), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_shift(req_shift), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_index(row_index), .row_last(row_last), .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_row(input int t, input int k, input int s);
    int v = t * 16 + k;
    if (s >= 8 || s <= -8) return 0;
    return s >= 0 ? (v << s) & 255 : v >> (-s);
  endfunction

  task automatic scan(input int t, input int s, input bit mess, input string tag);
    req_valid = 1; req_type = t[3:0]; req_shift = s[4:0];
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " valid"}, row_valid, 1);
      chk({tag, " data"}, row_data, exp_row(t, k, s));
      chk({tag, " index"}, row_index, k);
      chk({tag, " last"}, row_last, k == 7);
      chk({tag, " req_ready"}, req_ready, 0);
      chk({tag, " req_err"}, req_err, 0);
      got[k] = row_data;
      if (mess) begin
        req_valid = k != 7; req_type = 4'(k); req_shift = 5'(-k);
      end
      @(negedge clk);
    end
    chk({tag, " done valid"}, row_valid, 0);
    chk({tag, " done ready"}, req_ready, 1);
  endtask

  initial begin
    int pat, ek;
    for (int t = 1; t <= 5; t++)
      for (int k = 0; k < 8; k++) image[(t-1)*64 + k*8 +: 8] = {4'(t), 4'(k)};
    repeat (2) @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst row_valid", row_valid, 0);
    chk("rst row_data", row_data, 0);
    chk("rst row_index", row_index, 0);
    chk("rst row_last", row_last, 0);
    chk("rst req_err", req_err, 0);
    rst_n = 1; row_ready = 1;
    @(negedge clk);
    scan(3, 0, 0, "t1");
    chk("t1 row0", got[0], 8'h30);
    chk("t1 row7", got[7], 8'h37);
    scan(2, 2, 0, "t2a");
    chk("t2a row1", got[1], 8'h84);
    scan(2, -3, 0, "t2b");
    chk("t2b row7", got[7], 8'h04);
    scan(2, 8, 0, "t2c");
    for (int k = 0; k < 8; k++) chk("t2c zero", got[k], 0);
    // 2d: backpressure with a fixed irregular ready pattern
    pat = 32'hB269_4D3A; ek = 0;
    req_valid = 1; req_type = 5; req_shift = 5'(-1); row_ready = 0;
    @(negedge clk);
    req_valid = 0;
    for (int c = 0; c < 100 && ek < 8; c++) begin
      row_ready = pat[c % 32];
      chk("t2d valid", row_valid, 1);
      chk("t2d data", row_data, exp_row(5, ek, -1));
      chk("t2d index", row_index, ek);
      if (row_ready) ek++;
      @(negedge clk);
    end
    chk("t2d rows", ek, 8);
    chk("t2d done valid", row_valid, 0);
    row_ready = 1;
    // 3: invalid types
    for (int i = 0; i < 2; i++) begin
      req_valid = 1; req_type = i == 0 ? 4'd0 : 4'd6; req_shift = 0;
      @(negedge clk);
      req_valid = 0;
      chk("t3 err pulse", req_err, 1);
      chk("t3 no row", row_valid, 0);
      chk("t3 ready", req_ready, 1);
      @(negedge clk);
      chk("t3 err clear", req_err, 0);
      chk("t3 still idle", row_valid, 0);
    end
    scan(1, 0, 0, "t3 type1");
    // 4: back-to-back with req_valid held high
    req_valid = 1; req_type = 1; req_shift = 0;
    @(negedge clk);
    req_type = 5;
    for (int i = 0; i < 17; i++) begin
      if (i == 8) begin
        chk("t4 gap valid", row_valid, 0);
        chk("t4 gap ready", req_ready, 1);
      end else begin
        chk("t4 valid", row_valid, 1);
        chk("t4 data", row_data, i < 8 ? exp_row(1, i, 0) : exp_row(5, i - 9, 0));
      end
      if (i == 9) req_valid = 0;
      @(negedge clk);
    end
    chk("t4 end valid", row_valid, 0);
    chk("t4 end ready", req_ready, 1);
    // 5: reset in the middle of a scan
    req_valid = 1; req_type = 2; req_shift = 0;
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("t5 pre data", row_data, exp_row(2, k, 0));
      @(negedge clk);
    end
    rst_n = 0; row_ready = 0;
    @(negedge clk);
    chk("t5 rst valid", row_valid, 0);
    chk("t5 rst data", row_data, 0);
    chk("t5 rst ready", req_ready, 1);
    chk("t5 rst index", row_index, 0);
    rst_n = 1; row_ready = 1;
    @(negedge clk);
    chk("t5 quiet", row_valid, 0);
    scan(4, 0, 0, "t5 type4");
    // 6: request inputs scrambled during the scan
    scan(3, 1, 1, "t6");
    chk("t6 row3", got[3], 8'h66);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
